ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Shares the single-port IceRam between instruction fetch (read-only) and the
//  data/stack unit (read/write). It grants one requester per cycle, drives the
//  RAM address, mode and write data, and routes the 1-cycle-latency read data
//  back to the granted requester with a valid pulse. It sits between
//  FetchInstruction, the stack/data unit and ram0.
// PARAMETERS
//  addrBits   `ADDRESS_BITS  RAM word-address width
//  dataBits   `DATA_BITS     RAM word width
//  maxDataRun 4              max consecutive data grants while fetch waits (>=1)
//  protLimit  'h100          write-protect bound (ARB_WRITE_PROTECT_EN only)
// PORTS
//  clk            in   1         system clock; all state changes on posedge
//  reset          in   1         synchronous, active-high
//  fetchReq       in   1         fetch read request; addr held until grant
//  fetchAddress   in   addrBits  fetch word address
//  fetchGrant     out  1         fetch access issued to RAM this cycle
//  fetchValid     out  1         fetchData valid (1 cycle after fetchGrant)
//  fetchData      out  dataBits  read data for fetch
//  dataReq        in   1         data-unit request; addr/rw/wdata held to grant
//  dataAddress    in   addrBits  data word address
//  dataRw         in   1         `RAM_READ / `RAM_WRITE
//  dataWrite      in   dataBits  write data
//  dataGrant      out  1         data access issued to RAM this cycle
//  dataValid      out  1         dataRead valid (reads only, 1 cycle after grant)
//  dataRead       out  dataBits  read data for data unit
//  ramAddress     out  addrBits  to IceRam.address
//  ramRw          out  1         to IceRam.readWriteMode
//  ramDataIn      out  dataBits  to IceRam.dataIn
//  ramDataOut     in   dataBits  from IceRam.dataOut
//  protFault      out  1         (ARB_WRITE_PROTECT_EN) dropped-write pulse
// BEHAVIOUR
//  - Reset: grants, valids, protFault = 0; ramRw = `RAM_READ; ramAddress = 0;
//    runCount = 0; lastOwner = NONE. Reset mid-access kills any pending valid.
//  - Grant is combinational from req + registered state; grant cycle N drives
//    ramAddress/ramRw/ramDataIn in N; RAM samples at end of N.
//  - Read latency: *Valid high exactly in N+1; *Data = ramDataOut in N+1
//    (registered owner tag selects destination). Data outputs hold last value
//    otherwise. No valid for writes.
//  - Back-to-back: a requester may keep req high and be granted every cycle;
//    valids then pipeline one per cycle.
//  - Priority: data first. If both request and runCount == maxDataRun, fetch
//    wins. runCount: +1 on each data grant while fetchReq high, saturating;
//    cleared on any fetch grant or when fetchReq low.
//  - Idle (no req): no grant, ramRw = `RAM_READ, ramAddress holds last value.
//  - Owner state: NONE / FETCH / DATA, registered each cycle from the grant;
//    drives valid routing for N+1 only.
//  - Width rules: addresses pass unmodified; no wrap or arithmetic in block.
// CONFIGURATION
//  ARB_WRITE_PROTECT_EN defined: data write with dataAddress < protLimit is
//    granted (requester not stalled) but ramRw forced `RAM_READ; protFault
//    pulses 1 cycle in N+1; no dataValid. Undefined: all writes pass;
//    protFault port absent.
// TESTING (RAM preloaded word i = i, e.g. mem[14] = 'h0E)
//  1 reset high 2 cycles, no reqs -> grants/valids 0, ramRw = READ.
//  2 fetchReq addr 1 -> fetchGrant same cycle; next cycle fetchValid,
//    fetchData = 'h01; dataValid stays 0.
//  3 both req, fetch addr 2, data read addr 14 -> dataGrant first, dataRead
//    'h0E next cycle; fetch granted following cycle, fetchData = 'h02.
//  4 dataReq held, write then reads, fetchReq held -> after 4 data grants
//    fetch granted once; sequence D,D,D,D,F,D...
//  5 data write 'hAB to addr 'h200, then read 'h200 -> dataRead = 'hAB,
//    no dataValid on the write cycle.
//  6 ARB_WRITE_PROTECT_EN: write 'hFF to addr 3 -> protFault pulse; then
//    fetch addr 3 -> fetchData = 'h03. Reset during grant -> no valid next.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port RAM between instruction fetch
// (read-only) and the data/stack unit (read/write). Data has priority, but
// fetch is forced through after maxDataRun back-to-back data grants.
// Read data comes back one cycle after the grant and is steered by a
// registered owner tag.
// Optional feature macro: ARB_WRITE_PROTECT_EN (drops data writes below
// protLimit and pulses protFault instead).

`ifndef ADDRESS_BITS
`define ADDRESS_BITS 16
`endif
`ifndef DATA_BITS
`define DATA_BITS 16
`endif
`ifndef RAM_READ
`define RAM_READ 1'b0
`endif
`ifndef RAM_WRITE
`define RAM_WRITE 1'b1
`endif

module ram_port_arbiter #(
  parameter int addrBits   = `ADDRESS_BITS,
  parameter int dataBits   = `DATA_BITS,
  parameter int maxDataRun = 4,
  parameter int protLimit  = 'h100
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fetchReq,
  input  logic [addrBits-1:0] fetchAddress,
  output logic                fetchGrant,
  output logic                fetchValid,
  output logic [dataBits-1:0] fetchData,
  input  logic                dataReq,
  input  logic [addrBits-1:0] dataAddress,
  input  logic                dataRw,
  input  logic [dataBits-1:0] dataWrite,
  output logic                dataGrant,
  output logic                dataValid,
  output logic [dataBits-1:0] dataRead,
  output logic [addrBits-1:0] ramAddress,
  output logic                ramRw,
  output logic [dataBits-1:0] ramDataIn,
  input  logic [dataBits-1:0] ramDataOut
`ifdef ARB_WRITE_PROTECT_EN
  ,
  output logic                protFault
`endif
);

  localparam int runW = $clog2(maxDataRun + 1);
  localparam logic [runW-1:0] runMax = runW'(maxDataRun);

  // Owner of the access issued last cycle; only reads get a tag, since a
  // write has nothing to route back.
  typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DATA} owner_t;

  owner_t              owner, ownerNext;
  logic [runW-1:0]     runCount, runNext;
  logic [addrBits-1:0] addrHold;
  logic [dataBits-1:0] fetchHold, dataHold;
  logic                wrBlocked;

`ifdef ARB_WRITE_PROTECT_EN
  localparam logic [addrBits-1:0] protBound = addrBits'(protLimit);
  assign wrBlocked = (dataRw == `RAM_WRITE) && (dataAddress < protBound);
`else
  assign wrBlocked = 1'b0;
`endif

  // Write data needs no muxing: ramRw decides whether the RAM uses it.
  assign ramDataIn = dataWrite;

  // Grant decision, RAM drive and next owner/run count.
  always_comb begin
    fetchGrant = 1'b0;
    dataGrant  = 1'b0;
    ownerNext  = OWN_NONE;
    ramAddress = addrHold;
    ramRw      = `RAM_READ;
    runNext    = runCount;
    if (reset) begin
      ramAddress = '0;
      runNext    = '0;
    end else begin
      if (fetchReq && (!dataReq || runCount == runMax)) fetchGrant = 1'b1;
      else if (dataReq)                                  dataGrant  = 1'b1;

      if (fetchGrant) begin
        ramAddress = fetchAddress;
        ownerNext  = OWN_FETCH;
      end else if (dataGrant) begin
        ramAddress = dataAddress;
        if (dataRw == `RAM_WRITE) begin
          if (!wrBlocked) ramRw = `RAM_WRITE;
        end else begin
          ownerNext = OWN_DATA;
        end
      end

      // Run length only matters while fetch is actually waiting.
      if (fetchGrant || !fetchReq)                runNext = '0;
      else if (dataGrant && runCount != runMax)   runNext = runCount + 1'b1;
    end
  end

  // Owner tag, run counter and held address.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner    <= OWN_NONE;
      runCount <= '0;
      addrHold <= '0;
    end else begin
      owner    <= ownerNext;
      runCount <= runNext;
      addrHold <= ramAddress;
    end
  end

  assign fetchValid = (owner == OWN_FETCH);
  assign dataValid  = (owner == OWN_DATA);
  assign fetchData  = fetchValid ? ramDataOut : fetchHold;
  assign dataRead   = dataValid  ? ramDataOut : dataHold;

  // Keep the last delivered word so the data outputs hold between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetchHold <= '0;
      dataHold  <= '0;
    end else begin
      if (fetchValid) fetchHold <= ramDataOut;
      if (dataValid)  dataHold  <= ramDataOut;
    end
  end

`ifdef ARB_WRITE_PROTECT_EN
  // One-cycle fault pulse in the cycle after a dropped write.
  always_ff @(posedge clk) begin
    if (reset) protFault <= 1'b0;
    else       protFault <= dataGrant && wrBlocked;
  end
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: a vector table drives requests each cycle and
// checks grants/RAM drive; expected read returns are queued and compared one
// cycle later against the valid/data outputs.

`ifndef RAM_READ
`define RAM_READ 1'b0
`endif
`ifndef RAM_WRITE
`define RAM_WRITE 1'b1
`endif

module tb_ram_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          fetchReq, dataReq, dataRw;
  logic [AW-1:0] fetchAddress, dataAddress;
  logic [DW-1:0] dataWrite;
  logic          fetchGrant, fetchValid, dataGrant, dataValid, ramRw;
  logic [DW-1:0] fetchData, dataRead, ramDataIn;
  logic [DW-1:0] ramDataOut;
  logic [AW-1:0] ramAddress;
`ifdef ARB_WRITE_PROTECT_EN
  logic          protFault;
`endif

  ram_port_arbiter #(.addrBits(AW), .dataBits(DW), .maxDataRun(4), .protLimit('h100)) dut (
    .clk(clk), .reset(reset),
    .fetchReq(fetchReq), .fetchAddress(fetchAddress), .fetchGrant(fetchGrant),
    .fetchValid(fetchValid), .fetchData(fetchData),
    .dataReq(dataReq), .dataAddress(dataAddress), .dataRw(dataRw), .dataWrite(dataWrite),
    .dataGrant(dataGrant), .dataValid(dataValid), .dataRead(dataRead),
    .ramAddress(ramAddress), .ramRw(ramRw), .ramDataIn(ramDataIn), .ramDataOut(ramDataOut)
`ifdef ARB_WRITE_PROTECT_EN
    , .protFault(protFault)
`endif
  );

  always #5 clk = ~clk;

  // Single-port RAM with registered read, preloaded word i = i.
  logic [DW-1:0] mem [1024];
  always @(posedge clk) begin
    if (ramRw == `RAM_WRITE) mem[ramAddress[9:0]] <= ramDataIn;
    ramDataOut <= mem[ramAddress[9:0]];
  end

  typedef struct {
    bit          rst;
    bit          fReq;
    logic [15:0] fAddr;
    bit          dReq;
    logic [15:0] dAddr;
    bit          dRw;
    logic [15:0] dWr;
    bit          eF;
    bit          eD;
  } vec_t;

  typedef struct {
    bit          fV;
    bit          dV;
    bit          pF;
    logic [15:0] data;
  } exp_t;

  vec_t          vecs[$];
  exp_t          sb[$];
  logic [DW-1:0] refMem [1024];
  logic [AW-1:0] lastAddr;
  int            passed = 0;
  int            total  = 0;

  function automatic vec_t mk(bit rst, bit fR, logic [15:0] fA, bit dR, logic [15:0] dA,
                              bit rw, logic [15:0] wd, bit eF, bit eD);
    vec_t v;
    v.rst = rst; v.fReq = fR; v.fAddr = fA; v.dReq = dR; v.dAddr = dA;
    v.dRw = rw; v.dWr = wd; v.eF = eF; v.eD = eD;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // One cycle: check last cycle's returns, drive this cycle, check grants.
  task automatic step(input vec_t v);
    exp_t e;
    bit   prot, wr;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("fetchValid", {31'b0, fetchValid}, {31'b0, e.fV});
      chk("dataValid",  {31'b0, dataValid},  {31'b0, e.dV});
      if (e.fV) chk("fetchData", {16'b0, fetchData}, {16'b0, e.data});
      if (e.dV) chk("dataRead",  {16'b0, dataRead},  {16'b0, e.data});
`ifdef ARB_WRITE_PROTECT_EN
      chk("protFault", {31'b0, protFault}, {31'b0, e.pF});
`endif
    end
    reset = v.rst; fetchReq = v.fReq; fetchAddress = v.fAddr;
    dataReq = v.dReq; dataAddress = v.dAddr; dataRw = v.dRw; dataWrite = v.dWr;
    #1;
`ifdef ARB_WRITE_PROTECT_EN
    prot = v.dRw && (v.dAddr < 16'h100);
`else
    prot = 1'b0;
`endif
    wr = v.eD && v.dRw && !prot;
    chk("fetchGrant", {31'b0, fetchGrant}, {31'b0, v.eF});
    chk("dataGrant",  {31'b0, dataGrant},  {31'b0, v.eD});
    chk("ramRw", {31'b0, ramRw}, {31'b0, (wr ? `RAM_WRITE : `RAM_READ)});
    if (v.rst)     lastAddr = '0;
    else if (v.eF) lastAddr = v.fAddr;
    else if (v.eD) lastAddr = v.dAddr;
    chk("ramAddress", {16'b0, ramAddress}, {16'b0, lastAddr});
    if (wr) chk("ramDataIn", {16'b0, ramDataIn}, {16'b0, v.dWr});
    e.fV = v.eF;
    e.dV = v.eD && !v.dRw;
    e.pF = v.eD && v.dRw && prot;
    e.data = v.eF ? refMem[v.fAddr[9:0]] : refMem[v.dAddr[9:0]];
    sb.push_back(e);
    if (wr) refMem[v.dAddr[9:0]] = v.dWr;
    @(negedge clk);
  endtask

  localparam bit R = `RAM_READ;
  localparam bit W = `RAM_WRITE;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]    = DW'(i);
      refMem[i] = DW'(i);
    end
    lastAddr = '0;
    reset = 1'b1; fetchReq = 1'b0; dataReq = 1'b0; dataRw = R;
    fetchAddress = '0; dataAddress = '0; dataWrite = '0;

    //        rst fR fA      dR dA      rw wd      eF eD
    vecs.push_back(mk(1, 0, 16'h0,   0, 16'h0,   R, 16'h0,  0, 0)); // reset x2
    vecs.push_back(mk(1, 0, 16'h0,   0, 16'h0,   R, 16'h0,  0, 0));
    vecs.push_back(mk(0, 1, 16'h1,   0, 16'h0,   R, 16'h0,  1, 0)); // lone fetch
    vecs.push_back(mk(0, 0, 16'h0,   0, 16'h0,   R, 16'h0,  0, 0));
    vecs.push_back(mk(0, 1, 16'h2,   1, 16'hE,   R, 16'h0,  0, 1)); // data first
    vecs.push_back(mk(0, 1, 16'h2,   0, 16'h0,   R, 16'h0,  1, 0));
    vecs.push_back(mk(0, 0, 16'h0,   0, 16'h0,   R, 16'h0,  0, 0));
    vecs.push_back(mk(0, 1, 16'h7,   1, 16'h300, W, 16'h55, 0, 1)); // run of 4
    vecs.push_back(mk(0, 1, 16'h7,   1, 16'h300, R, 16'h0,  0, 1));
    vecs.push_back(mk(0, 1, 16'h7,   1, 16'h5,   R, 16'h0,  0, 1));
    vecs.push_back(mk(0, 1, 16'h7,   1, 16'h6,   R, 16'h0,  0, 1));
    vecs.push_back(mk(0, 1, 16'h7,   1, 16'h8,   R, 16'h0,  1, 0)); // fetch forced
    vecs.push_back(mk(0, 0, 16'h0,   1, 16'h8,   R, 16'h0,  0, 1));
    vecs.push_back(mk(0, 0, 16'h0,   1, 16'h200, W, 16'hAB, 0, 1)); // write no valid
    vecs.push_back(mk(0, 0, 16'h0,   1, 16'h200, R, 16'h0,  0, 1));
    vecs.push_back(mk(0, 0, 16'h0,   0, 16'h0,   R, 16'h0,  0, 0));
    vecs.push_back(mk(0, 0, 16'h0,   1, 16'h3,   W, 16'hFF, 0, 1)); // low write
    vecs.push_back(mk(0, 1, 16'h3,   0, 16'h0,   R, 16'h0,  1, 0));
    vecs.push_back(mk(0, 0, 16'h0,   0, 16'h0,   R, 16'h0,  0, 0));

    @(negedge clk);
    foreach (vecs[i]) step(vecs[i]);

    // Reset mid-run clears the run counter: full 4 data grants again.
    step(mk(0, 1, 16'h9, 1, 16'hA, R, 16'h0, 0, 1));
    step(mk(0, 1, 16'h9, 1, 16'hA, R, 16'h0, 0, 1));
    step(mk(1, 1, 16'h9, 1, 16'hA, R, 16'h0, 0, 0));
    for (int k = 0; k < 4; k++) step(mk(0, 1, 16'h9, 1, 16'hB, R, 16'h0, 0, 1));
    step(mk(0, 1, 16'h9, 1, 16'hB, R, 16'h0, 1, 0));
    // Fetch granted, then reset arrives with request still up: no valid after.
    step(mk(0, 1, 16'h4, 0, 16'h0, R, 16'h0, 1, 0));
    step(mk(1, 1, 16'h4, 0, 16'h0, R, 16'h0, 0, 0));
    step(mk(0, 0, 16'h0, 0, 16'h0, R, 16'h0, 0, 0));
    step(mk(0, 0, 16'h0, 0, 16'h0, R, 16'h0, 0, 0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
